mda_char_fetch: RTL and testbench

- Front end of the MDA text pipeline: the producer side of the attribute stage. Per character cell it fetches the character and attribute bytes from VRAM and the glyph row from the font ROM, then serialises 9-dot pixels.
- Drives att_byte, pix, cursor, blink and display_enable, cycle-aligned, into the attribute/pixel combiner.
- Sits between the CRTC timing outputs (ma, row_addr, cursor, de, vsync) and the attribute stage. Runs in the single video clock domain, qualified by a dot strobe.

---
 rtl/mda_char_fetch.sv | 112 +++++++++++
 tb/tb_mda_char_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mda_char_fetch.sv
// mda_char_fetch: MDA per-cell VRAM/font fetch and 9-dot pixel serialiser
// Ports: clk/reset (async, active-high); dot_ce, line_start pace the dots;
// ma, row_addr, cursor_in, de_in, vsync come from the CRTC; vram_* is the
// VRAM read handshake; font_addr/font_data talk to a synchronous font ROM;
// att_byte, pix, cursor, blink, display_enable feed the attribute stage;
// overrun is sticky until reset.
module mda_char_fetch #(
  parameter int BLINK_FRAMES = 16,
  parameter int FONT_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dot_ce,
  input  logic               line_start,
  input  logic [10:0]        ma,
  input  logic [4:0]         row_addr,
  input  logic               cursor_in,
  input  logic               de_in,
  input  logic               vsync,
  output logic [11:0]        vram_addr,
  output logic               vram_rd,
  input  logic               vram_ack,
  input  logic [7:0]         vram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic [7:0]         att_byte,
  output logic               pix,
  output logic               cursor,
  output logic               blink,
  output logic               display_enable,
  output logic               overrun
);
  typedef enum logic [2:0] {IDLE, RD_CHAR, RD_ATTR, FONT, FLATCH} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [10:0] ma_q;
  logic [7:0] code_n, att_n, glyph_n, g;
  logic cur_n, de_n, valid_n, vs_q, bnd, load;
  logic [8:0] sh, v;
  logic [4:0] fc;
  assign bnd = dot_ce & (line_start | cnt == 4'd0);
  // Fetched data is shown only if it completed and this is not a line's first cell.
  assign load = valid_n & ~line_start & state == IDLE;
  assign g = load ? glyph_n : 8'h00;
  // Line-drawing codes C0..DF stretch glyph bit 0 into the ninth dot.
  assign v = {g, code_n[7:5] == 3'b110 & g[0]};
  // A boundary aborts any read in flight within the same clk.
  assign vram_rd = (state == RD_CHAR | state == RD_ATTR) & ~bnd;
  assign vram_addr = {ma_q, state == RD_ATTR};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ma_q <= '0;
      code_n <= '0;
      att_n <= '0;
      glyph_n <= '0;
      cur_n <= 1'b0;
      de_n <= 1'b0;
      valid_n <= 1'b0;
      vs_q <= 1'b0;
      sh <= '0;
      fc <= '0;
      font_addr <= '0;
      att_byte <= '0;
      pix <= 1'b0;
      cursor <= 1'b0;
      blink <= 1'b0;
      display_enable <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vs_q <= vsync;
      if (vsync & ~vs_q) begin
        fc <= fc == 5'(BLINK_FRAMES - 1) ? 5'd0 : fc + 5'd1;
        blink <= fc == 5'(BLINK_FRAMES - 1) ? ~blink : blink;
      end
      if (dot_ce) begin
        cnt <= bnd ? 4'd1 : cnt == 4'd8 ? 4'd0 : cnt + 4'd1;
        pix <= bnd ? v[8] : sh[8];
        sh <= bnd ? {v[7:0], 1'b0} : {sh[7:0], 1'b0};
      end
      if (bnd) begin
        att_byte <= load ? att_n : 8'h00;
        display_enable <= load & de_n;
        cursor <= cur_n;
        ma_q <= ma;
        cur_n <= cursor_in;
        de_n <= de_in;
        valid_n <= 1'b0;
        overrun <= overrun | state != IDLE;
        state <= RD_CHAR;
      end else
        case (state)
          RD_CHAR: if (vram_ack) begin
            code_n <= vram_data;
            state <= RD_ATTR;
          end
          RD_ATTR: if (vram_ack) begin
            att_n <= vram_data;
            font_addr <= FONT_AW'({code_n, row_addr[3:0]});
            state <= FONT;
          end
          FONT: state <= FLATCH;
          FLATCH: begin
            glyph_n <= font_data;
            valid_n <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_mda_char_fetch.sv
// tb_mda_char_fetch: randomized self-checking bench for mda_char_fetch
module tb_mda_char_fetch;
  logic clk = 0, reset = 0, dot_ce = 0, line_start = 0, cursor_in = 0, de_in = 0, vsync = 0;
  logic vram_ack = 0, vram_rd, pix, cursor, blink, display_enable, overrun;
  logic [10:0] ma = 0;
  logic [4:0] row_addr = 0;
  logic [7:0] vram_data = 0, font_data = 0, att_byte;
  logic [11:0] vram_addr, font_addr;
  logic [7:0] vmem [4096];
  logic [7:0] fmem [4096];
  int errors = 0, checks = 0;
  logic hold = 0;
  int wcnt = 0, dly = 0;
  logic [11:0] acks [$];
  int tb_cnt = 0;
  logic pv_ok = 0, pv_cur = 0, pv_de = 0;
  logic [10:0] pv_ma = 0;
  logic [3:0] pv_row = 0;
  logic [8:0] edots = 0, seen = 0;
  logic [7:0] ea = 0;
  logic ecur = 0, ede = 0;

  mda_char_fetch #(.BLINK_FRAMES(16), .FONT_AW(12)) dut (
    .clk(clk), .reset(reset), .dot_ce(dot_ce), .line_start(line_start), .ma(ma),
    .row_addr(row_addr), .cursor_in(cursor_in), .de_in(de_in), .vsync(vsync),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_ack(vram_ack), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data), .att_byte(att_byte), .pix(pix),
    .cursor(cursor), .blink(blink), .display_enable(display_enable), .overrun(overrun));

  always #5 clk = ~clk;

  // VRAM responder with random latency, and a synchronous font ROM.
  always @(posedge clk) begin
    font_data <= fmem[font_addr];
    vram_ack <= 1'b0;
    if (vram_rd && !vram_ack && !hold) begin
      if (wcnt >= dly) begin
        vram_ack <= 1'b1;
        vram_data <= vmem[vram_addr];
        wcnt <= 0;
        dly <= $urandom_range(0, 3);
        acks.push_back(vram_addr);
      end else wcnt <= wcnt + 1;
    end else if (!vram_rd) wcnt <= 0;
  end

  // One dot: pulse dot_ce, then check against the cell-level model.
  task automatic dot_step(input logic ls);
    int d;
    logic [7:0] code, gl;
    @(negedge clk);
    dot_ce = 1;
    line_start = ls;
    @(negedge clk);
    dot_ce = 0;
    line_start = 0;
    d = ls ? 0 : tb_cnt;
    tb_cnt = (d == 8) ? 0 : d + 1;
    if (d == 0) begin
      if (ls || !pv_ok) begin
        code = 0; gl = 0; ea = 0; ede = 0;
      end else begin
        code = vmem[{pv_ma, 1'b0}];
        ea = vmem[{pv_ma, 1'b1}];
        gl = fmem[{code, pv_row}];
        ede = pv_de;
      end
      ecur = pv_cur;
      edots = {gl, (code >= 8'hC0 && code <= 8'hDF) ? gl[0] : 1'b0};
      pv_ma = ma; pv_cur = cursor_in; pv_de = de_in; pv_row = row_addr[3:0]; pv_ok = 1;
      checks++;
      if (att_byte !== ea || display_enable !== ede || cursor !== ecur) begin
        errors++;
        $display("FAIL cell_attr got att=%h de=%b cur=%b exp att=%h de=%b cur=%b",
                 att_byte, display_enable, cursor, ea, ede, ecur);
      end
    end
    seen[8-d] = pix;
    checks++;
    if (pix !== edots[8-d]) begin
      errors++;
      $display("FAIL pix dot=%0d got=%b exp=%b", d, pix, edots[8-d]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_char(input logic [10:0] m, input logic [4:0] r, input logic ls);
    ma = m;
    row_addr = r;
    cursor_in = 1'($urandom);
    de_in = 1'($urandom);
    dot_step(ls);
    for (int i = 0; i < 8; i++) dot_step(0);
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #1;
    checks++;
    if ({vram_rd, pix, att_byte, cursor, blink, display_enable, overrun, vram_addr, font_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state got rd=%b pix=%b att=%h blink=%b ovr=%b addr=%h exp all 0",
               vram_rd, pix, att_byte, blink, overrun, vram_addr);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_blink;
    for (int n = 1; n <= 48; n++) begin
      vsync = 1;
      repeat (2) @(negedge clk);
      vsync = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (blink !== 1'((n / 16) % 2)) begin
        errors++;
        $display("FAIL blink pulse=%0d got=%b exp=%b", n, blink, 1'((n / 16) % 2));
      end
    end
  endtask

  task automatic test_basic;
    vmem[12'h020] = 8'h41; vmem[12'h021] = 8'h07; fmem[{8'h41, 4'h3}] = 8'h3C;
    vmem[12'h022] = 8'hC4; vmem[12'h023] = 8'h70; fmem[{8'hC4, 4'h3}] = 8'hFF;
    vmem[12'h024] = 8'h41; vmem[12'h025] = 8'h0F; fmem[{8'h41, 4'h5}] = 8'h01;
    acks.delete();
    run_char(11'h010, 5'd3, 0);
    checks++;
    if (acks.size() < 2 || acks[0] !== 12'h020 || acks[1] !== 12'h021) begin
      errors++;
      $display("FAIL vram_addr got n=%0d first=%h exp 020,021", acks.size(), acks.size() ? acks[0] : 12'h0);
    end
    run_char(11'h011, 5'd3, 0);
    checks++;
    if (seen !== 9'b001111000 || att_byte !== 8'h07) begin
      errors++;
      $display("FAIL char41 got dots=%b att=%h exp 001111000 07", seen, att_byte);
    end
    run_char(11'h012, 5'd5, 0);
    checks++;
    if (seen !== 9'h1FF) begin
      errors++;
      $display("FAIL charC4 got dots=%b exp 111111111", seen);
    end
    run_char(11'h013, 5'd5, 0);
    checks++;
    if (seen !== 9'b000000010) begin
      errors++;
      $display("FAIL dot8 got dots=%b exp 000000010", seen);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_char(11'($urandom), 5'($urandom), ($urandom_range(0, 5) == 0));
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL no_overrun got=%b exp=0", overrun);
    end
  endtask

  task automatic test_line_start;
    run_char(11'h200, 5'd7, 0);
    for (int i = 0; i < 5; i++) dot_step(0);
    ma = 11'h345;
    de_in = 1;
    dot_step(1);
    checks++;
    if (display_enable !== 1'b0 || att_byte !== 8'h00) begin
      errors++;
      $display("FAIL ls_blank got de=%b att=%h exp 0 00", display_enable, att_byte);
    end
    for (int i = 0; i < 8; i++) dot_step(0);
    run_char(11'h346, 5'd7, 0);
    checks++;
    if (att_byte !== vmem[12'h68B] || display_enable !== 1'b1) begin
      errors++;
      $display("FAIL ls_second got att=%h de=%b exp %h 1", att_byte, display_enable, vmem[12'h68B]);
    end
  endtask

  task automatic test_overrun;
    hold = 1;
    run_char(11'h100, 5'd2, 0);
    pv_ok = 0;
    acks.delete();
    ma = 11'h101;
    de_in = 1;
    dot_step(0);
    hold = 0;
    checks++;
    if (overrun !== 1'b1 || display_enable !== 1'b0) begin
      errors++;
      $display("FAIL overrun got ovr=%b de=%b exp 1 0", overrun, display_enable);
    end
    for (int i = 0; i < 8; i++) dot_step(0);
    checks++;
    if (acks.size() == 0 || acks[0] !== 12'h202) begin
      errors++;
      $display("FAIL restart got first=%h exp 202", acks.size() ? acks[0] : 12'h0);
    end
    run_char(11'h102, 5'd2, 0);
    run_char(11'h103, 5'd2, 0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got=%b exp=1", overrun);
    end
  endtask

  task automatic test_async_reset;
    hold = 1;
    ma = 11'h055;
    dot_step(0);
    checks++;
    if (vram_rd !== 1'b1) begin
      errors++;
      $display("FAIL rd_pending got=%b exp=1", vram_rd);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({vram_rd, pix, att_byte, blink, overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset got rd=%b pix=%b att=%h blink=%b ovr=%b exp all 0",
               vram_rd, pix, att_byte, blink, overrun);
    end
    @(negedge clk);
    reset = 0;
    hold = 0;
    tb_cnt = 0; pv_ok = 0; pv_cur = 0; pv_de = 0; edots = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (vram_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rd=%b exp=0", vram_rd);
    end
    run_char(11'h3A0, 5'd1, 0);
    run_char(11'h3A1, 5'd1, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      vmem[i] = 8'($urandom);
      fmem[i] = 8'($urandom);
    end
    test_reset;
    test_blink;
    test_basic;
    test_random;
    test_line_start;
    test_overrun;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
